// File: rtl/logic_eval_scheduler_if.sv
// ---------------------------------------------------------------------------
// logic_eval_scheduler_if
// Request/response bundle between the datapath clients and the shared
// logic-function scheduler.
//   req_valid [NUM_REQ]    per-requester request valid      (client -> sched)
//   req_ready [NUM_REQ]    per-requester accept, one-hot    (sched  -> client)
//   req_x/y   [NUM_REQ*W]  operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready    response handshake
//   rsp_id    [IDW]        requester whose result is presented
//   rsp_za/zb/z [W]        stage-A, stage-B and combined results
// master = client/consumer side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface logic_eval_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int W       = 4,
  localparam int IDW    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*W-1:0] req_x;
  logic [NUM_REQ*W-1:0] req_y;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [W-1:0]         rsp_za;
  logic [W-1:0]         rsp_zb;
  logic [W-1:0]         rsp_z;

  modport master (
    output req_valid, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_za, rsp_zb, rsp_z
  );

  modport slave (
    input  req_valid, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_za, rsp_zb, rsp_z
  );
endinterface

// File: rtl/logic_eval_scheduler.sv
// ---------------------------------------------------------------------------
// logic_eval_scheduler
// Round-robin arbiter in front of one bitwise logic unit. A granted request
// is evaluated over three dedicated cycles (z_a = x & ~y, z_b = ~(x ^ y),
// z = (z_a | z_b) ^ (z_a & z_b)) and then presented on the response channel.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        logic_eval_scheduler_if.slave (request and response channels)
//   busy       high whenever the FSM is not IDLE
//   eval_count saturating count of completed responses
// ---------------------------------------------------------------------------
module logic_eval_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int W       = 4,
  parameter int CNTW    = 16,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  logic_eval_scheduler_if.slave   bus,
  output logic                    busy,
  output logic [CNTW-1:0]         eval_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EVAL_A = 3'd1,
    EVAL_B = 3'd2,
    COMB   = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     id_q;
  logic [W-1:0]       x_q, y_q, za_q, zb_q, z_q;
  logic [CNTW-1:0]    cnt_q;

  logic [IDW-1:0]     grant_idx;
  logic               grant_found;
  logic [IDW:0]       cand;
  logic [W-1:0]       sel_x, sel_y;
  logic               accept;
  logic               rsp_fire;
  logic [NUM_REQ-1:0] ready_vec;

  // Round-robin search starting at ptr_q. Walking the offsets from the
  // farthest to the nearest lets the nearest valid requester win.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NUM_REQ))
        cand = cand - (IDW+1)'(NUM_REQ);
      if (bus.req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  // Grant is only offered in IDLE and never while reset is asserted, so
  // req_ready reads all-zero during reset even if requesters are valid.
  assign accept = (state_q == IDLE) && grant_found && rst_n;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign ready_vec[gi] = accept && (grant_idx == IDW'(gi));
    end
  endgenerate

  assign bus.req_ready = ready_vec;

  // Operand mux for the granted requester.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_x = bus.req_x[i*W +: W];
        sel_y = bus.req_y[i*W +: W];
      end
    end
  end

  assign ptr_d = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = EVAL_A;
      EVAL_A:  state_d = EVAL_B;
      EVAL_B:  state_d = COMB;
      COMB:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign rsp_fire = (state_q == RESP) && bus.rsp_ready;

  // Datapath: operands are captured only at the request handshake, and each
  // stage register is written in its own dedicated state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      id_q  <= '0;
      x_q   <= '0;
      y_q   <= '0;
      za_q  <= '0;
      zb_q  <= '0;
      z_q   <= '0;
      cnt_q <= '0;
    end else begin
      if (accept) begin
        x_q   <= sel_x;
        y_q   <= sel_y;
        id_q  <= grant_idx;
        ptr_q <= ptr_d;
      end
      if (state_q == EVAL_A) za_q <= x_q & ~y_q;
      if (state_q == EVAL_B) zb_q <= ~(x_q ^ y_q);
      if (state_q == COMB)   z_q  <= (za_q | zb_q) ^ (za_q & zb_q);
      if (rsp_fire && (cnt_q != '1)) cnt_q <= cnt_q + CNTW'(1);
    end
  end

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_za    = za_q;
  assign bus.rsp_zb    = zb_q;
  assign bus.rsp_z     = z_q;
  assign busy          = (state_q != IDLE);
  assign eval_count    = cnt_q;

endmodule
